snake_collision_check: RTL and testbench
========================================

SNAKE_COLLISION_CHECK -- requirements
Module: snake_collision_check

Consumes the packed body vectors from the snake position shift registers. Each move it reports wall, self and apple hits to the game FSM and relocates the apple when it is eaten.

Interface
REQ-001 Parameter N, default 4: maximum segment count; equals the shift register's maxLength.
REQ-002 Parameter XDIM, default 10: segment/apple width in pixels.
REQ-003 Parameter YDIM, default 10: segment/apple height in pixels.
REQ-004 Parameter XSCREEN, default 160: screen width in pixels.
REQ-005 Parameter YSCREEN, default 120: screen height in pixels.
REQ-006 Parameter SEED, default 16'hACE1: LFSR reset value; must be non-zero.
REQ-007 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port start, input, 1: request one check; sampled only in IDLE.
REQ-010 Port body_x, input, 8*N: segment i at [8i+7:8i]; segment N-1 (MSB slice) is the head.
REQ-011 Port body_y, input, 7*N: segment i at [7i+6:7i]; same ordering as body_x.
REQ-012 Port length, input, 3: number of active segments counted from the head.
REQ-013 Port apple_x, input, 8: current apple top-left X.
REQ-014 Port apple_y, input, 7: current apple top-left Y.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when results are valid.
REQ-017 Port wall_hit, output, 1: head is outside the playfield.
REQ-018 Port self_hit, output, 1: head equals an active body segment.
REQ-019 Port apple_eaten, output, 1: head box overlaps the apple box.
REQ-020 Port new_apple_x, output, 8: registered relocated apple X.
REQ-021 Port new_apple_y, output, 7: registered relocated apple Y.

Function
REQ-022 The FSM SHALL have states IDLE, WALL, SCAN, APPLE, RELOC, DONE; all outputs are registered.
REQ-023 IDLE with start=1 SHALL latch body_x, body_y, length, apple_x and apple_y, clear the three flags, load scan index k=1, and go to WALL.
REQ-024 start SHALL be ignored while busy=1; inputs changing after the latch SHALL NOT affect results.
REQ-025 Length handling: length=0 SHALL be treated as 1, and length>N SHALL be treated as N.
REQ-026 WALL SHALL set wall_hit when head_x > XSCREEN-XDIM or head_y > YSCREEN-YDIM (unsigned; a left/up underflow wrap, e.g. x=255, counts as a hit).
REQ-027 WALL SHALL then go to SCAN if effective length >= 2, else to APPLE.
REQ-028 SCAN SHALL compare one segment per cycle: segment N-1-k, for k = 1 .. length-1.
REQ-029 In SCAN, self_hit SHALL be set when both X and Y match the head exactly.
REQ-030 SCAN SHALL have no early exit; after k = length-1 it goes to APPLE.
REQ-031 APPLE SHALL set apple_eaten when |head_x-apple_x| < XDIM and |head_y-apple_y| < YDIM, using 9-bit/8-bit signed differences.
REQ-032 APPLE SHALL go to RELOC if apple_eaten, else to DONE.
REQ-033 The LFSR SHALL be a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clock in every state.
REQ-034 In RELOC, the candidate SHALL be X = lfsr[7:0], Y = lfsr[14:8].
REQ-035 A RELOC candidate SHALL be accepted if X <= XSCREEN-XDIM, Y <= YSCREEN-YDIM, and it does not overlap the head box under the REQ-031 rule.
REQ-036 On acceptance, RELOC SHALL load new_apple_x/new_apple_y and go to DONE; otherwise it retries next cycle.
REQ-037 After 16 rejected RELOC tries, RELOC SHALL load the fallback (30,30) and go to DONE.
REQ-038 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-039 Flags SHALL hold their values until the next accepted start.
REQ-040 Latency SHALL be start-to-done = 2 + max(length-1,0) + 1 + R cycles, where R = RELOC cycles used (0..17).
REQ-041 new_apple_x/new_apple_y SHALL change only in RELOC or on reset.

Reset
REQ-042 Reset SHALL take effect at any state, mid-scan or mid-relocation included.
REQ-043 On reset, state SHALL go to IDLE; busy, done, wall_hit, self_hit and apple_eaten SHALL be 0.
REQ-044 On reset, new_apple SHALL be (30,30), lfsr SHALL be SEED, and k SHALL be 0.
REQ-045 start held during the reset cycle SHALL be ignored.

Verification
REQ-046 Head (80,60), body (80,70),(80,80),(80,90), length 4, apple (30,30) -> all flags 0; done 6 cycles after start.
REQ-047 Head (151,60), length 1 -> wall_hit=1; head (255,60) -> wall_hit=1; head (150,110) -> wall_hit=0.
REQ-048 Head (80,60), segment N-3 = (80,60), length 4 -> self_hit=1; same vectors with length 2 -> self_hit=0.
REQ-049 Head (35,39), apple (30,30) -> apple_eaten=1 and new_apple within [0..150]x[0..110] not overlapping the head; head (40,30) -> apple_eaten=0.
REQ-050 Assert reset during SCAN -> the next cycle shows busy=0, flags 0, new_apple (30,30); a second start pulse while busy -> exactly one done.

Source files
------------

// File: rtl/snake_collision_check.sv
// Per-move collision checker for the snake game: latches the body snapshot, then reports wall,
// self and apple hits and relocates an eaten apple using a free-running LFSR.
module snake_collision_check #(
    parameter int unsigned N       = 4,
    parameter int unsigned XDIM    = 10,
    parameter int unsigned YDIM    = 10,
    parameter int unsigned XSCREEN = 160,
    parameter int unsigned YSCREEN = 120,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [8*N-1:0] body_x,
    input  logic [7*N-1:0] body_y,
    input  logic [2:0]     length,
    input  logic [7:0]     apple_x,
    input  logic [6:0]     apple_y,
    output logic           busy,
    output logic           done,
    output logic           wall_hit,
    output logic           self_hit,
    output logic           apple_eaten,
    output logic [7:0]     new_apple_x,
    output logic [6:0]     new_apple_y
);

    localparam logic [7:0] XMAX  = 8'(XSCREEN - XDIM);
    localparam logic [6:0] YMAX  = 7'(YSCREEN - YDIM);
    localparam logic [7:0] FB_X  = 8'd30;
    localparam logic [6:0] FB_Y  = 7'd30;

    typedef enum logic [2:0] {StIdle, StWall, StScan, StApple, StReloc, StDone} state_e;

    state_e           state_q;
    logic [8*N-1:0]   bx_q;
    logic [7*N-1:0]   by_q;
    logic [2:0]       len_q;
    logic [7:0]       ax_q;
    logic [6:0]       ay_q;
    logic [2:0]       k_q;
    logic [4:0]       tries_q;
    logic [15:0]      lfsr_q;

    logic [2:0]       len_eff;
    logic [7:0]       head_x, seg_x, cand_x;
    logic [6:0]       head_y, seg_y, cand_y;
    int unsigned      seg_idx;
    logic             eat, cand_ok;

    // Box overlap test using signed differences, so a wrapped coordinate stays far away.
    function automatic logic overlap(input logic [7:0] x0, input logic [6:0] y0,
                                     input logic [7:0] x1, input logic [6:0] y1);
        logic signed [8:0] dx;
        logic signed [7:0] dy;
        logic [8:0]        adx;
        logic [7:0]        ady;
        dx  = $signed({1'b0, x0}) - $signed({1'b0, x1});
        dy  = $signed({1'b0, y0}) - $signed({1'b0, y1});
        adx = (dx < 0) ? $unsigned(-dx) : $unsigned(dx);
        ady = (dy < 0) ? $unsigned(-dy) : $unsigned(dy);
        return (adx < 9'(XDIM)) && (ady < 8'(YDIM));
    endfunction

    always_comb begin
        len_eff = length;
        if (length == 3'd0) begin
            len_eff = 3'd1;
        end else if (32'(length) > N) begin
            len_eff = 3'(N);
        end
    end

    always_comb begin
        seg_idx = N - 1 - 32'(k_q);
        head_x  = bx_q[8*(N-1) +: 8];
        head_y  = by_q[7*(N-1) +: 7];
        seg_x   = bx_q[8*seg_idx +: 8];
        seg_y   = by_q[7*seg_idx +: 7];
        cand_x  = lfsr_q[7:0];
        cand_y  = lfsr_q[14:8];
        eat     = overlap(head_x, head_y, ax_q, ay_q);
        cand_ok = (cand_x <= XMAX) && (cand_y <= YMAX) && !overlap(head_x, head_y, cand_x, cand_y);
    end

    // Free-running so relocation draws differ from move to move.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            wall_hit    <= 1'b0;
            self_hit    <= 1'b0;
            apple_eaten <= 1'b0;
            new_apple_x <= FB_X;
            new_apple_y <= FB_Y;
            k_q         <= 3'd0;
            tries_q     <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        bx_q        <= body_x;
                        by_q        <= body_y;
                        len_q       <= len_eff;
                        ax_q        <= apple_x;
                        ay_q        <= apple_y;
                        wall_hit    <= 1'b0;
                        self_hit    <= 1'b0;
                        apple_eaten <= 1'b0;
                        k_q         <= 3'd1;
                        tries_q     <= 5'd0;
                        busy        <= 1'b1;
                        state_q     <= StWall;
                    end
                end
                StWall: begin
                    wall_hit <= (head_x > XMAX) || (head_y > YMAX);
                    state_q  <= (len_q >= 3'd2) ? StScan : StApple;
                end
                StScan: begin
                    if (seg_x == head_x && seg_y == head_y) begin
                        self_hit <= 1'b1;
                    end
                    if (k_q == 3'(len_q - 3'd1)) begin
                        state_q <= StApple;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                StApple: begin
                    apple_eaten <= eat;
                    if (eat) begin
                        state_q <= StReloc;
                    end else begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StReloc: begin
                    if (tries_q == 5'd16) begin
                        new_apple_x <= FB_X;
                        new_apple_y <= FB_Y;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end else if (cand_ok) begin
                        new_apple_x <= cand_x;
                        new_apple_y <= cand_y;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        tries_q <= tries_q + 5'd1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_collision_check.sv
// Table-driven bench for snake_collision_check with a scoreboard queue of expected results.
module tb_snake_collision_check;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           reset, start;
    logic [8*N-1:0] body_x;
    logic [7*N-1:0] body_y;
    logic [2:0]     length;
    logic [7:0]     apple_x;
    logic [6:0]     apple_y;
    logic           busy, done, wall_hit, self_hit, apple_eaten;
    logic [7:0]     new_apple_x;
    logic [6:0]     new_apple_y;

    snake_collision_check #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .body_x      (body_x),
        .body_y      (body_y),
        .length      (length),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .busy        (busy),
        .done        (done),
        .wall_hit    (wall_hit),
        .self_hit    (self_hit),
        .apple_eaten (apple_eaten),
        .new_apple_x (new_apple_x),
        .new_apple_y (new_apple_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] bx;
        logic [27:0] by;
        logic [2:0]  len;
        logic [7:0]  ax;
        logic [6:0]  ay;
        logic        wall;
        logic        slf;
        logic        eat;
    } vec_t;

    typedef struct {
        logic       wall;
        logic       slf;
        logic       eat;
        logic [7:0] nx;
        logic [6:0] ny;
        int         lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[14];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] lfsr_m;
    logic [7:0]  nax_m;
    logic [6:0]  nay_m;

    function automatic logic [15:0] lnext(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic bit ovl(input int x0, input int y0, input int x1, input int y1);
        int dx, dy;
        dx = (x0 > x1) ? x0 - x1 : x1 - x0;
        dy = (y0 > y1) ? y0 - y1 : y1 - y0;
        return (dx < 10) && (dy < 10);
    endfunction

    // Reference LFSR, advanced on the same edges as the design's.
    always @(posedge clk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= lnext(lfsr_m);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        nax_m = 8'd30;
        nay_m = 7'd30;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t        e;
        int          le, r, cyc;
        logic [15:0] l;
        int          tries;
        logic [7:0]  hx;
        logic [6:0]  hy;
        @(negedge clk);
        body_x  = v.bx;
        body_y  = v.by;
        length  = v.len;
        apple_x = v.ax;
        apple_y = v.ay;
        start   = 1'b1;
        le = (v.len == 0) ? 1 : ((int'(v.len) > 4) ? 4 : int'(v.len));
        hx = v.bx[31:24];
        hy = v.by[27:21];
        r  = 0;
        if (v.eat) begin
            l = lfsr_m;
            for (int i = 0; i < le + 2; i++) l = lnext(l);
            tries = 0;
            for (int t = 0; t < 17; t++) begin
                r++;
                if (tries == 16) begin
                    nax_m = 8'd30;
                    nay_m = 7'd30;
                    break;
                end
                if (l[7:0] <= 150 && l[14:8] <= 110 && !ovl(hx, hy, l[7:0], l[14:8])) begin
                    nax_m = l[7:0];
                    nay_m = l[14:8];
                    break;
                end
                tries++;
                l = lnext(l);
            end
        end
        e.wall = v.wall;
        e.slf  = v.slf;
        e.eat  = v.eat;
        e.nx   = nax_m;
        e.ny   = nay_m;
        e.lat  = le + 2 + r;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk({v.name, " busy"}, {31'b0, busy}, 32'd1);
        while (done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk({v.name, " done_seen"}, {31'b0, done}, 32'd1);
        chk({v.name, " latency"}, cyc, e.lat);
        chk({v.name, " wall_hit"}, {31'b0, wall_hit}, {31'b0, e.wall});
        chk({v.name, " self_hit"}, {31'b0, self_hit}, {31'b0, e.slf});
        chk({v.name, " apple_eaten"}, {31'b0, apple_eaten}, {31'b0, e.eat});
        chk({v.name, " new_apple_x"}, {24'b0, new_apple_x}, {24'b0, e.nx});
        chk({v.name, " new_apple_y"}, {25'b0, new_apple_y}, {25'b0, e.ny});
        if (e.eat) begin
            chk({v.name, " new_apple_range"},
                {31'b0, (new_apple_x <= 150 && new_apple_y <= 110 &&
                         !ovl(hx, hy, new_apple_x, new_apple_y))}, 32'd1);
        end
        @(negedge clk);
        chk({v.name, " done_pulse"}, {31'b0, done}, 32'd0);
        chk({v.name, " busy_end"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int ndone;
        logic wall_at_done;
        reset   = 1'b1;
        start   = 1'b0;
        body_x  = '0;
        body_y  = '0;
        length  = 3'd0;
        apple_x = 8'd0;
        apple_y = 7'd0;
        // bx/by pack {head, seg2, seg1, seg0}
        vecs[0]  = '{"basic", {8'd80, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd70, 7'd80, 7'd90},
                     3'd4, 8'd30, 7'd30, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"wall_x151", {8'd151, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd30, 7'd30, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"wall_x255", {8'd255, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd30, 7'd30, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"edge_150_110", {8'd150, 8'd80, 8'd80, 8'd80}, {7'd110, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd30, 7'd30, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"self_len4", {8'd80, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd70, 7'd60, 7'd90},
                     3'd4, 8'd30, 7'd30, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{"self_len2", {8'd80, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd70, 7'd60, 7'd90},
                     3'd2, 8'd30, 7'd30, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"eat_35_39", {8'd35, 8'd80, 8'd80, 8'd80}, {7'd39, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd30, 7'd30, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"miss_40_30", {8'd40, 8'd80, 8'd80, 8'd80}, {7'd30, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd30, 7'd30, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"len0", {8'd80, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd60, 7'd80, 7'd90},
                     3'd0, 8'd30, 7'd30, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"len7_clamp", {8'd80, 8'd80, 8'd80, 8'd80}, {7'd60, 7'd70, 7'd80, 7'd60},
                     3'd7, 8'd30, 7'd30, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{"eat_origin", {8'd0, 8'd80, 8'd80, 8'd80}, {7'd0, 7'd70, 7'd80, 7'd90},
                     3'd2, 8'd5, 7'd5, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{"wall_y127", {8'd80, 8'd80, 8'd80, 8'd80}, {7'd127, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd30, 7'd30, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{"all_three", {8'd255, 8'd255, 8'd80, 8'd80}, {7'd60, 7'd60, 7'd80, 7'd90},
                     3'd4, 8'd250, 7'd55, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{"eat_corner", {8'd145, 8'd80, 8'd80, 8'd80}, {7'd105, 7'd70, 7'd80, 7'd90},
                     3'd1, 8'd150, 7'd110, 1'b0, 1'b0, 1'b1};

        do_reset();
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst flags", {29'b0, wall_hit, self_hit, apple_eaten}, 32'd0);
        chk("rst new_apple", {17'b0, new_apple_x, new_apple_y}, {17'b0, 8'd30, 7'd30});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Flags hold while idle.
        run_vec(vecs[1]);
        repeat (5) @(negedge clk);
        chk("sticky wall_hit", {31'b0, wall_hit}, 32'd1);

        // Reset in the middle of a scan, with start held through the reset cycle.
        @(negedge clk);
        body_x = vecs[12].bx;
        body_y = vecs[12].by;
        length = 3'd4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_scan wall", {31'b0, wall_hit}, 32'd1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        nax_m = 8'd30;
        nay_m = 7'd30;
        chk("scan_rst busy", {31'b0, busy}, 32'd0);
        chk("scan_rst flags", {29'b0, wall_hit, self_hit, apple_eaten}, 32'd0);
        chk("scan_rst new_apple", {17'b0, new_apple_x, new_apple_y}, {17'b0, 8'd30, 7'd30});
        @(negedge clk);
        chk("rst_start ignored", {31'b0, busy}, 32'd0);

        // Second start and input changes while busy must not disturb the run.
        @(negedge clk);
        body_x  = vecs[0].bx;
        body_y  = vecs[0].by;
        length  = 3'd4;
        apple_x = 8'd30;
        apple_y = 7'd30;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        body_x = vecs[12].bx;
        body_y = vecs[12].by;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        wall_at_done = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                wall_at_done = wall_hit;
            end
        end
        chk("busy_start done_count", ndone, 32'd1);
        chk("busy_start wall", {31'b0, wall_at_done}, 32'd0);

        run_vec(vecs[6]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
